// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dm_state_t;

    localparam logic [3:0] BE_B0 = 4'b0001;
    localparam logic [3:0] BE_B1 = 4'b0010;
    localparam logic [3:0] BE_B2 = 4'b0100;
    localparam logic [3:0] BE_B3 = 4'b1000;
    localparam logic [3:0] BE_H0 = 4'b0011;
    localparam logic [3:0] BE_H1 = 4'b1100;
    localparam logic [3:0] BE_W  = 4'b1111;

    localparam int DM_DEFAULT_DEPTH = 3072;

endpackage

// File: rtl/dm_be_check.sv
// Byte-enable legality: pattern must be a naturally aligned byte,
// halfword or word, and addr[1:0] must match its lowest lane.
module dm_be_check
    import dm_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [3:0] be,
    output logic       legal
);

    always_comb begin
        legal = 1'b0;
        unique case (be)
            BE_B0, BE_H0, BE_W: legal = (addr_lo == 2'd0);
            BE_B1:              legal = (addr_lo == 2'd1);
            BE_B2, BE_H1:       legal = (addr_lo == 2'd2);
            BE_B3:              legal = (addr_lo == 2'd3);
            default:            legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Wait-stated data-memory slave for the core's load/store port.
// Define DM_WRITE_LOG_EN to print committed stores and illegal requests.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH_WORDS = DM_DEFAULT_DEPTH,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L = 30'(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    dm_state_t   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        enter_resp;
    logic        cur_we;
    logic [31:0] cur_addr;
    logic [3:0]  cur_be;
    logic [31:0] cur_wdata;
    logic [31:0] cur_pc;
    logic        be_ok;
    logic        in_range;
    logic        legal;
    logic [IDX_W-1:0] mem_idx;
    logic [31:0] old_word;
    logic [31:0] new_word;
    logic        mem_we;

    // With zero wait states the commit edge is the acceptance edge,
    // so the live request is used before it reaches the latch.
    always_comb begin
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_addr  = req_addr;
            cur_be    = req_be;
            cur_wdata = req_wdata;
            cur_pc    = req_pc;
        end else begin
            cur_we    = we_q;
            cur_addr  = addr_q;
            cur_be    = be_q;
            cur_wdata = wdata_q;
            cur_pc    = pc_q;
        end
    end

    dm_be_check u_be_check (
        .addr_lo (cur_addr[1:0]),
        .be      (cur_be),
        .legal   (be_ok)
    );

    always_comb begin
        in_range = (cur_addr[31:2] < DEPTH_L);
        legal    = be_ok && in_range;
        mem_idx  = cur_addr[IDX_W+1:2];
        old_word = in_range ? mem_q[mem_idx] : 32'd0;
        for (int i = 0; i < 4; i++) begin
            new_word[8*i +: 8] = cur_be[i] ? cur_wdata[8*i +: 8]
                                           : old_word[8*i +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    pc_d    = req_pc;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_we      = enter_resp && cur_we && legal;
        rsp_err_d   = enter_resp && !legal;
        rsp_rdata_d = (enter_resp && !cur_we && legal) ? old_word : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
            pc_q        <= 32'd0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            pc_q        <= pc_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (mem_we) begin
            mem_q[mem_idx] <= new_word;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef DM_WRITE_LOG_EN
    always @(posedge clk) begin
        if (!reset) begin
            if (mem_we) begin
                $display("@%08h: *%08h <= %08h",
                         cur_pc, {cur_addr[31:2], 2'b00}, new_word);
            end
            if (enter_resp && !legal) begin
                $display("@%08h: DM error addr %08h be %01h",
                         cur_pc, cur_addr, cur_be);
            end
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^cur_pc;
`endif

endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder for the MIPS core: the slave side of the core's load/store port. It accepts one request at a time over a valid/ready handshake, applies a configurable number of wait states, performs a byte-enable-masked write or a whole-word read, and returns the result as a one-cycle response pulse. It replaces the zero-latency data memory so the core's stall logic can be exercised against realistic memory latency.

## Interface
Parameters:
- DEPTH_WORDS, 3072: number of 32-bit words. Valid byte addresses are 0 to DEPTH_WORDS*4-1.
- WAIT_CYCLES, 2: wait states between acceptance and response. Allowed range is 0–15.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_be  in  4  byte-lane enables; bit i selects byte i of the word.
- req_wdata  in  32  store data, already lane-aligned.
- req_pc  in  32  PC of the issuing instruction; used only for logging.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  whole word read, or 0 when rsp_err is set or for stores.
- rsp_err  out  1  request was illegal.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**
  - req_ready=1.
  - A request is accepted on an edge where req_valid && req_ready.
  - On acceptance, latch we, addr, be, wdata and pc.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- **WAIT**
  - A 4-bit counter loads WAIT_CYCLES-1 on acceptance and decrements each cycle.
  - The transition to RESP occurs on the edge where the counter is 0.
- **RESP**
  - rsp_valid=1 for exactly one cycle, then IDLE.
  - No backpressure: the core must be stalled and sample rsp_valid itself.
- **Legality** (checked on the latched request):
  - be must be one of 0001, 0010, 0100, 1000, 0011, 1100, 1111.
  - addr[1:0] must equal the index of the lowest set bit of be.
  - addr[31:2] must be < DEPTH_WORDS.
  - Any violation gives rsp_err=1: no write, rsp_rdata=0.
- **Store:** on the edge entering RESP, each byte lane i with be[i]=1 is written with wdata[8i+7:8i]; other lanes are unchanged. rsp_rdata=0.
- **Load:** the word at addr[31:2] is captured on the edge entering RESP, so it reflects all earlier stores. Byte/halfword extraction is the core's responsibility.
- Only one request is ever outstanding, so read-after-write is always coherent.

## Timing
- Values while reset is asserted:
  - State is IDLE, counter is 0.
  - req_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All memory words are 0.
- Latency: rsp_valid is high in cycle N+WAIT_CYCLES+1, where N is the acceptance cycle.
- Throughput: the next acceptance is possible at the earliest in the cycle after rsp_valid, i.e. one request per WAIT_CYCLES+2 cycles.
- req_ready is low throughout WAIT and RESP. req_valid is ignored in those states, including in the RESP cycle.
- rsp_rdata and rsp_err are registered, valid only while rsp_valid=1, and are 0 otherwise.
- Reset mid-operation: the pending request is dropped, no response is issued, and a not-yet-committed store is never written.
- reset deassertion: a request can be accepted on the first rising edge after deassertion.

## Configuration
- DM_WRITE_LOG_EN defined:
  - Every committed store prints `@<pc>: *<word-aligned addr> <= <full resulting word>` (all hex, 8 digits) at the commit edge.
  - Illegal requests print `@<pc>: DM error addr <addr> be <be>`.
- DM_WRITE_LOG_EN undefined:
  - No print statements are compiled.
  - Functional behaviour is identical.

## Structure
- Package dm_pkg holds:
  - the state enum type dm_state_t (IDLE/WAIT/RESP);
  - the legal be constants BE_B0–BE_B3, BE_H0, BE_H1, BE_W;
  - DM_DEFAULT_DEPTH = 3072.
- Sub-module dm_be_check, combinational:
  - inputs: addr[1:0], be;
  - output: legal.
  - dm_responder adds the range check.
- Top module holds:
  - the FSM;
  - the wait counter;
  - the request latch;
  - the memory array;
  - the logging.

## Test plan
- Reset then idle: req_ready=1, rsp_valid=0. A word load from address 0x0 with WAIT_CYCLES=2 gives rsp_valid exactly 3 cycles after acceptance, rdata=0x00000000, err=0.
- Store word: addr 0x10, be=1111, wdata=0x12345678. Then store byte: addr 0x11, be=0010, wdata=0x0000AB00. Then load 0x10: rdata=0x1234AB78.
- Illegal requests:
  - addr 0x13 with be=0011 gives err=1, rdata=0, memory unchanged.
  - addr 0x3000 at depth 3072 gives err=1.
- WAIT_CYCLES=0: back-to-back requests with req_valid held high are accepted every 2nd cycle, and rsp_valid follows each acceptance by 1 cycle. req_valid in the RESP cycle is not accepted.
- Reset asserted during WAIT of a store to 0x20 with wdata=0xDEADBEEF: no rsp_valid, and a later load of 0x20 returns 0x00000000.
- With DM_WRITE_LOG_EN, a store at pc 0x00003004 of 0x000000FF to 0x4, be=1111, prints `@00003004: *00000004 <= 000000ff`.
